fb_mem_arbiter: RTL and testbench

- Responder side of the framebuffer request/broadcast protocol.
- Accepts read and write requests from two requesters over rts/rtr handshakes:
  - port 0: read-modify-write engine;
  - port 1: display fetch engine.
- Arbitrates round-robin and drives one single-port synchronous framebuffer RAM.
- Returns read data on a shared data bus, with a one-cycle bcast_xfc pulse to the requester that issued the read.

---
 rtl/fb_mem_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 33 +++
 rtl/fb_mem_arbiter.sv | 106 ++++++++++
 tb/tb_fb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_mem_pkg.sv
// Shared types and defaults for the framebuffer memory arbiter.
package fb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    BCAST   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 32;
  localparam int WE_W_DEF   = 4;

  localparam logic [3:0] WR_OP_READ = 4'b0000;
  localparam logic [3:0] WR_OP_FULL = 4'b1111;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the port that did not win last time wins a tie.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic       grant,
  output logic       grant_valid
);

  logic last_grant_reg;

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant_reg;
    end else if (req[1]) begin
      grant = 1'b1;
    end
    grant_valid = enable & (|req);
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      last_grant_reg <= 1'b1;
    end else if (advance) begin
      last_grant_reg <= grant;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM responder: arbitrates two requesters onto one single-port
// synchronous RAM and broadcasts read data back to the issuing port.
module fb_mem_arbiter
  import fb_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WE_W   = WE_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic [WE_W-1:0]   p0_wr_op,
  input  logic              p0_rts,
  output logic              p0_rtr,
  output logic              p0_bcast_xfc,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic [WE_W-1:0]   p1_wr_op,
  input  logic              p1_rts,
  output logic              p1_rtr,
  output logic              p1_bcast_xfc,
  output logic [DATA_W-1:0] bcast_data,
  output logic              mem_en,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

  state_t              state_reg, state_next;
  logic [2:0]          cnt_reg;
  logic                owner_reg;
  logic [WE_W-1:0]     wr_op_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   bcast_data_reg;
  logic                grant;
  logic                grant_valid;
  logic                xfc;

  rr_arbiter_2 u_rr (
    .clk         (clk),
    .rst_        (rst_),
    .req         ({p1_rts, p0_rts}),
    .enable      (state_reg == IDLE),
    .advance     (xfc),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign p0_rtr = grant_valid & ~grant;
  assign p1_rtr = grant_valid & grant;
  assign xfc    = (p0_rts & p0_rtr) | (p1_rts & p1_rtr);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfc) state_next = ACCESS;
      ACCESS:  state_next = (wr_op_reg != WE_W'(WR_OP_READ)) ? IDLE : RD_WAIT;
      RD_WAIT: if (cnt_reg == 3'd1) state_next = BCAST;
      BCAST:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg      <= IDLE;
      cnt_reg        <= 3'd0;
      owner_reg      <= 1'b0;
      wr_op_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      bcast_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (xfc) begin
        mem_addr_reg  <= grant ? p1_addr  : p0_addr;
        mem_wdata_reg <= grant ? p1_data  : p0_data;
        wr_op_reg     <= grant ? p1_wr_op : p0_wr_op;
        owner_reg     <= grant;
      end
      if (state_reg == ACCESS) begin
        cnt_reg <= RD_LAT_CNT;
      end else if (state_reg == RD_WAIT) begin
        cnt_reg <= cnt_reg - 3'd1;
        // Final wait cycle is the one in which the RAM output is valid.
        if (cnt_reg == 3'd1) bcast_data_reg <= mem_rdata;
      end
    end
  end

  assign mem_en       = (state_reg == ACCESS);
  assign mem_we       = mem_en ? wr_op_reg : '0;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign bcast_data   = bcast_data_reg;
  assign p0_bcast_xfc = (state_reg == BCAST) & ~owner_reg;
  assign p1_bcast_xfc = (state_reg == BCAST) & owner_reg;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: RD_LAT=1 instance driven by directed
// requests, plus an RD_LAT=3 instance for the long-latency timing.
module tb_fb_mem_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic preload = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RD_LAT=1 instance
  logic [16:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_data = '0, p1_data = '0;
  logic [3:0]  p0_wr_op = '0, p1_wr_op = '0;
  logic        p0_rts = 1'b0, p1_rts = 1'b0;
  logic        p0_rtr, p1_rtr, p0_bcast_xfc, p1_bcast_xfc, mem_en;
  logic [31:0] bcast_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_we;
  logic [16:0] mem_addr;
  logic [31:0] ram [0:511];

  fb_mem_arbiter #(.RD_LAT(LAT)) u_dut (
    .clk(clk), .rst_(rst_),
    .p0_addr(p0_addr), .p0_data(p0_data), .p0_wr_op(p0_wr_op), .p0_rts(p0_rts),
    .p0_rtr(p0_rtr), .p0_bcast_xfc(p0_bcast_xfc),
    .p1_addr(p1_addr), .p1_data(p1_data), .p1_wr_op(p1_wr_op), .p1_rts(p1_rts),
    .p1_rtr(p1_rtr), .p1_bcast_xfc(p1_bcast_xfc),
    .bcast_data(bcast_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: read data is valid only in the single cycle LAT after mem_en.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
      ram[9'h011] <= 32'h12345678;
      ram[9'h020] <= 32'hCAFE0020;
      ram[9'h030] <= 32'h0BAD0030;
      ram[9'h100] <= 32'h12345678;
      ram[9'h101] <= 32'h87654321;
      ram[9'h102] <= 32'hFFFFFFFF;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[8:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem_en ? ram[mem_addr[8:0]] : 32'h0;
  end

  // RD_LAT=3 instance
  logic [16:0] q0_addr = '0, q1_addr = '0;
  logic [31:0] q0_data = '0, q1_data = '0;
  logic [3:0]  q0_wr_op = '0, q1_wr_op = '0;
  logic        q0_rts = 1'b0, q1_rts = 1'b0;
  logic        q0_rtr, q1_rtr, q0_bcast_xfc, q1_bcast_xfc, q_mem_en;
  logic [31:0] q_bcast_data, q_mem_wdata;
  logic [3:0]  q_mem_we;
  logic [16:0] q_mem_addr;
  logic [31:0] q_pipe [0:2];
  logic [31:0] ram3 [0:15];

  fb_mem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_(rst_),
    .p0_addr(q0_addr), .p0_data(q0_data), .p0_wr_op(q0_wr_op), .p0_rts(q0_rts),
    .p0_rtr(q0_rtr), .p0_bcast_xfc(q0_bcast_xfc),
    .p1_addr(q1_addr), .p1_data(q1_data), .p1_wr_op(q1_wr_op), .p1_rts(q1_rts),
    .p1_rtr(q1_rtr), .p1_bcast_xfc(q1_bcast_xfc),
    .bcast_data(q_bcast_data), .mem_en(q_mem_en), .mem_we(q_mem_we),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_rdata(q_pipe[2])
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram3[i] <= 32'h0;
      ram3[5] <= 32'h5A5A0005;
    end
    q_pipe[0] <= q_mem_en ? ram3[q_mem_addr[3:0]] : 32'h0;
    q_pipe[1] <= q_pipe[0];
    q_pipe[2] <= q_pipe[1];
  end

  // Scoreboard
  typedef struct { int cyc; logic [3:0] we; logic [16:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { int cyc; bit port; logic [31:0] data; } bc_exp_t;
  mem_exp_t mem_q[$];
  bc_exp_t  bc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input string detail);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  task automatic push(input int t, input bit port, input logic [16:0] addr,
                      input logic [31:0] data, input logic [3:0] op, input logic [31:0] rd);
    mem_q.push_back('{t + 1, op, addr, data});
    if (op == 4'h0) bc_q.push_back('{t + 2 + LAT, port, rd});
  endtask

  // Monitor: pops expectations when the DUT presents mem_en or a bcast strobe.
  int       next_free = 0;
  mem_exp_t me;
  bc_exp_t  be;
  logic [3:0] xop;
  always begin
    @(negedge clk);
    #2;
    if (!rst_) begin
      next_free = 0;
    end else begin
      if (mem_en) begin
        if (mem_q.size() == 0) miss("mem_en_unexpected", "got mem_en=1, expected 0");
        else begin
          me = mem_q.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(me.cyc));
          chk("mem_we", 64'(mem_we), 64'(me.we));
          chk("mem_addr", 64'(mem_addr), 64'(me.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
        end
      end else if (mem_we != 4'h0) begin
        chk("mem_we_idle", 64'(mem_we), 64'(0));
      end
      if (p0_bcast_xfc || p1_bcast_xfc) begin
        if (bc_q.size() == 0) miss("bcast_unexpected", "got bcast_xfc=1, expected 0");
        else begin
          be = bc_q.pop_front();
          chk("bcast_cycle", 64'(cyc), 64'(be.cyc));
          chk("bcast_port", 64'({p1_bcast_xfc, p0_bcast_xfc}), 64'(be.port ? 2'b10 : 2'b01));
          chk("bcast_data", 64'(bcast_data), 64'(be.data));
        end
      end
      while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
        me = mem_q.pop_front();
        miss("mem_en_missing", $sformatf("got no mem_en, expected one at cycle %0d", me.cyc));
      end
      while (bc_q.size() > 0 && bc_q[0].cyc < cyc) begin
        be = bc_q.pop_front();
        miss("bcast_missing", $sformatf("got no bcast, expected one at cycle %0d", be.cyc));
      end
      if (p0_rtr || p1_rtr) begin
        chk("rtr_both", 64'({p1_rtr, p0_rtr} == 2'b11), 64'(0));
        chk("rtr_without_rts", 64'({p1_rtr, p0_rtr} & ~{p1_rts, p0_rts}), 64'(0));
        chk("rtr_while_busy", 64'(cyc >= next_free), 64'(1));
        if ((p0_rtr && p0_rts) || (p1_rtr && p1_rts)) begin
          xop = (p0_rtr && p0_rts) ? p0_wr_op : p1_wr_op;
          next_free = cyc + ((xop != 4'h0) ? 2 : 3 + LAT);
        end
      end
    end
  end

  // Stimulus helpers
  task automatic drive(input bit port, input logic [16:0] addr, input logic [31:0] data,
                       input logic [3:0] op, input logic rts);
    if (port) begin p1_addr = addr; p1_data = data; p1_wr_op = op; p1_rts = rts; end
    else      begin p0_addr = addr; p0_data = data; p0_wr_op = op; p0_rts = rts; end
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
  task automatic req(input bit port, input logic [16:0] addr, input logic [31:0] data,
                     input logic [3:0] op, input logic [31:0] rd, output int t);
    int n;
    n = 0;
    t = -1;
    drive(port, addr, data, op, 1'b1);
    #1;
    while (t < 0 && n < 20) begin
      if (port ? p1_rtr : p0_rtr) t = cyc;
      else begin @(negedge clk); #1; n++; end
    end
    if (t < 0) miss("req_timeout", $sformatf("got no rtr on port %0d, expected one", port));
    else push(t, port, addr, data, op, rd);
    @(posedge clk);
    #1;
    drive(port, 17'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mem_q.size() > 0 || bc_q.size() > 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) miss("drain_timeout", "got pending expectations, expected none");
    @(negedge clk);
  endtask

  task automatic wait_rtr(output int t, output bit port);
    int n;
    n = 0;
    t = -1;
    port = 1'b0;
    #1;
    while (t < 0 && n < 20) begin
      if (p0_rtr || p1_rtr) begin t = cyc; port = p1_rtr; end
      else begin @(negedge clk); #1; n++; end
    end
    if (t < 0) miss("grant_timeout", "got no rtr, expected one");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected one");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int t1, t2, t3, t, tprev;
    bit gp;
    logic [31:0] w, got;
    logic [31:0] pre_rd [0:2];
    logic [3:0]  colors [0:2];
    pre_rd = '{32'h12345678, 32'h87654321, 32'hFFFFFFFF};
    colors = '{4'hA, 4'hB, 4'hC};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", 64'({p0_rtr, p1_rtr, p0_bcast_xfc, p1_bcast_xfc, mem_en, mem_we}), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset_bcast_data", 64'(bcast_data), 64'(0));
    preload = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;

    // Contention: both ports read continuously; grants must alternate from port 0.
    drive(1'b0, 17'h20, 32'h11111111, 4'h0, 1'b1);
    drive(1'b1, 17'h30, 32'h22222222, 4'h0, 1'b1);
    tprev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_rtr(t, gp);
      if (t >= 0) begin
        chk("contention_grant", 64'(gp), 64'(g % 2));
        if (gp) push(t, 1'b1, 17'h30, 32'h22222222, 4'h0, 32'h0BAD0030);
        else    push(t, 1'b0, 17'h20, 32'h11111111, 4'h0, 32'hCAFE0020);
        if (g > 0) chk("contention_gap", 64'(t - tprev), 64'(3 + LAT));
        tprev = t;
      end
      @(negedge clk);
    end
    drive(1'b0, 17'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 17'h0, 32'h0, 4'h0, 1'b0);
    drain();

    // Single write, immediate read-back on port 1, then a byte-masked write.
    req(1'b0, 17'h00010, 32'hDEADBEEF, 4'hF, 32'h0, t1);
    req(1'b1, 17'h00010, 32'h0, 4'h0, 32'hDEADBEEF, t2);
    chk("write_next_xfc", 64'(t2 - t1), 64'(2));
    req(1'b0, 17'h00011, 32'h000000AA, 4'b0001, 32'h0, t3);
    chk("read_next_xfc", 64'(t3 - t2), 64'(3 + LAT));
    drain();

    // Read-modify-write of nibble 3 on three words through port 0.
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 17'h100 + 17'(i), 32'h0, 4'h0, pre_rd[i], t);
      got = 32'h0;
      for (int n = 0; n < 10 && !p0_bcast_xfc; n++) begin @(negedge clk); #1; end
      if (p0_bcast_xfc) got = bcast_data;
      else miss("rmw_bcast_timeout", "got no p0_bcast_xfc, expected one");
      @(negedge clk);
      w = got;
      w[15:12] = colors[i];
      req(1'b0, 17'h100 + 17'(i), w, 4'hF, 32'h0, t);
    end
    drain();
    chk("ram_0x010", 64'(ram[9'h010]), 64'(32'hDEADBEEF));
    chk("ram_0x011", 64'(ram[9'h011]), 64'(32'h123456AA));
    chk("ram_0x100", 64'(ram[9'h100]), 64'(32'h1234A678));
    chk("ram_0x101", 64'(ram[9'h101]), 64'(32'h8765B321));
    chk("ram_0x102", 64'(ram[9'h102]), 64'(32'hFFFFCFFF));

    // Reset in RD_WAIT: outputs clear at once, no bcast follows, port 0 wins next tie.
    req(1'b0, 17'h20, 32'h0, 4'h0, 32'hCAFE0020, t);
    @(posedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    bc_q.delete();
    chk("midrst_ctrl", 64'({p0_rtr, p1_rtr, p0_bcast_xfc, p1_bcast_xfc, mem_en, mem_we}), 64'(0));
    chk("midrst_mem_addr", 64'(mem_addr), 64'(0));
    chk("midrst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("midrst_bcast_data", 64'(bcast_data), 64'(0));
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (6) @(negedge clk);
    drive(1'b0, 17'h30, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 17'h20, 32'h0, 4'h0, 1'b1);
    wait_rtr(t, gp);
    if (t >= 0) begin
      chk("post_reset_grant", 64'(gp), 64'(0));
      if (gp) push(t, 1'b1, 17'h20, 32'h0, 4'h0, 32'hCAFE0020);
      else    push(t, 1'b0, 17'h30, 32'h0, 4'h0, 32'h0BAD0030);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 17'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 17'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    drain();

    // RD_LAT=3 instance: mem_en at T+1, bcast at T+5, next rtr at T+6.
    q0_addr = 17'h5;
    q0_wr_op = 4'h0;
    q0_rts = 1'b1;
    #1;
    chk("lat3_first_rtr", 64'(q0_rtr), 64'(1));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lat3_mem_en_T+%0d", k), 64'(q_mem_en), 64'(k == 1));
      chk($sformatf("lat3_bcast_T+%0d", k), 64'({q1_bcast_xfc, q0_bcast_xfc}), 64'(k == 5 ? 2'b01 : 2'b00));
      chk($sformatf("lat3_rtr_T+%0d", k), 64'(q0_rtr), 64'(k == 6));
      if (k == 5) chk("lat3_bcast_data", 64'(q_bcast_data), 64'(32'h5A5A0005));
    end
    @(posedge clk);
    #1;
    q0_rts = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
